bist_signature_analyzer: RTL and testbench
==========================================

BIST_SIGNATURE_ANALYZER -- requirements
Module: bist_signature_analyzer

Interface
REQ-001 Parameter SIG_W, default 8: signature register width in bits.
REQ-002 Parameter RESP_W, default 3: width of the circuit-under-test response (6:3 counter output).
REQ-003 Parameter MISR_POLY, default 8'h1D: feedback tap mask for x^8+x^4+x^3+x^2+1.
REQ-004 Parameter PAT_CNT, default 63: number of valid responses compacted per test.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: begins a test session.
REQ-008 Port resp, input, RESP_W: circuit-under-test output word.
REQ-009 Port resp_valid, input, 1: resp is valid this cycle.
REQ-010 Port golden, input, SIG_W: expected signature; sampled in CMP.
REQ-011 Port busy, output, 1: high in RUN and CMP.
REQ-012 Port done, output, 1: high in DONE.
REQ-013 Port pass, output, 1: compare result; meaningful only while done=1.
REQ-014 Port signature, output, SIG_W: current MISR contents.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, CMP and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL clear the signature and the accepted-response counter, then enter RUN.
REQ-017 In RUN, each cycle with resp_valid=1 SHALL update the signature once and increment the counter.
REQ-018 MISR update SHALL be: next = (sig<<1) XOR (sig[SIG_W-1] ? MISR_POLY : 0) XOR zero-extend(resp).
REQ-019 Cycles with resp_valid=0 SHALL leave the signature and counter unchanged.
REQ-020 When the PAT_CNT-th response is accepted, the FSM SHALL enter CMP on the next edge.
REQ-021 CMP SHALL last exactly one cycle; it registers pass = (signature == golden), then enters DONE.
REQ-022 Latency: PAT_CNT-th accept at edge t gives the final signature at t; done=1 and valid pass from edge t+1.
REQ-023 resp_valid SHALL be ignored in IDLE, CMP and DONE.
REQ-024 start SHALL be ignored in RUN and CMP.
REQ-025 DONE SHALL hold done, pass and signature stable until start or reset.
REQ-026 The counter SHALL be ceil(log2(PAT_CNT+1)) bits wide and SHALL never wrap within a session.

Reset
REQ-027 reset=1 SHALL force IDLE, signature=0, counter=0, busy=0, done=0, pass=0, on the same edge and from any state.
REQ-028 reset SHALL take priority over start and resp_valid in the same cycle.
REQ-029 A reset during RUN SHALL abort the session; no partial result is reported.

Structure
REQ-030 Shared package bist_pkg SHALL hold the RESP_W and SIG_W defaults, the MISR_POLY default and the FSM state typedef.
REQ-031 The MISR register and update SHALL be a sub-module, misr, with ports clk, reset, clr, en, din and sig.
REQ-032 The FSM, counter and comparator SHALL reside in bist_signature_analyzer.

Verification
REQ-033 PAT_CNT=2; start; resp 001 then 000 -> signature 0x01 then 0x02; golden=0x02 -> done=1, pass=1.
REQ-034 PAT_CNT=9; resp 001, then eight 000 -> signature 0x80 after 8 accepts, 0x1D after 9; golden=0x1C -> pass=0.
REQ-035 PAT_CNT=63; all-zero responses with resp_valid toggling every other cycle -> 63 accepts, signature 0x00, done 1 cycle after last accept.
REQ-036 Reset asserted mid-RUN (after 5 accepts) -> next cycle IDLE, signature 0, busy 0; a new start yields results identical to a fresh session.
REQ-037 start pulsed during RUN and CMP -> ignored; start in DONE -> signature cleared, busy=1, done=0 next cycle.
REQ-038 start and reset asserted together -> IDLE with all outputs 0.

Source files
------------

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared defaults and FSM state type for the BIST signature analyzer
package bist_pkg;

  localparam int SIG_W_DEF  = 8;
  localparam int RESP_W_DEF = 3;
  // x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [7:0] MISR_POLY_DEF = 8'h1D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/misr.sv
// rtl/misr.sv - multiple-input signature register compacting one response word per enable
module misr #(
  parameter int               SIG_W  = 8,
  parameter int               RESP_W = 3,
  parameter logic [SIG_W-1:0] POLY   = 8'h1D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_nx;

  always_comb begin
    sig_nx = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nx;
    end
  end

endmodule

// File: rtl/bist_signature_analyzer.sv
// rtl/bist_signature_analyzer.sv - session FSM, accept counter and golden compare around the MISR
module bist_signature_analyzer
  import bist_pkg::*;
#(
  parameter int               SIG_W     = SIG_W_DEF,
  parameter int               RESP_W    = RESP_W_DEF,
  parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(MISR_POLY_DEF),
  parameter int               PAT_CNT   = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RESP_W-1:0] resp,
  input  logic              resp_valid,
  input  logic [SIG_W-1:0]  golden,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam int CNT_W = $clog2(PAT_CNT + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             clr;
  logic             accept;
  logic             last;

  assign last = (cnt == CNT_W'(PAT_CNT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clr      = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (resp_valid) begin
          accept = 1'b1;
          if (last) begin
            state_nx = CMP;
          end
        end
      end
      CMP: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // counter stops at PAT_CNT because RUN is left on the final accept
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pass <= 1'b0;
    end else if (state == CMP) begin
      pass <= (signature == golden);
    end
  end

  assign busy = (state == RUN) || (state == CMP);
  assign done = (state == DONE);

  misr #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (accept),
    .din   (resp),
    .sig   (signature)
  );

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// tb/tb_bist_signature_analyzer.sv - scoreboard bench over three analyzer instances (PAT_CNT 2, 9, 63)
module tb_bist_signature_analyzer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       resp_valid;
  logic [2:0] resp;
  logic [7:0] golden;
  int         sel;

  logic [2:0] st_v, rv_v;
  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic [7:0] sig_w  [3];

  always #5 clk = ~clk;

  assign st_v[0] = start && (sel == 0);
  assign st_v[1] = start && (sel == 1);
  assign st_v[2] = start && (sel == 2);
  assign rv_v[0] = resp_valid && (sel == 0);
  assign rv_v[1] = resp_valid && (sel == 1);
  assign rv_v[2] = resp_valid && (sel == 2);

  bist_signature_analyzer #(.PAT_CNT(2)) u_dut0 (
    .clk(clk), .reset(reset), .start(st_v[0]), .resp(resp), .resp_valid(rv_v[0]),
    .golden(golden), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0])
  );
  bist_signature_analyzer #(.PAT_CNT(9)) u_dut1 (
    .clk(clk), .reset(reset), .start(st_v[1]), .resp(resp), .resp_valid(rv_v[1]),
    .golden(golden), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1])
  );
  bist_signature_analyzer #(.PAT_CNT(63)) u_dut2 (
    .clk(clk), .reset(reset), .start(st_v[2]), .resp(resp), .resp_valid(rv_v[2]),
    .golden(golden), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .signature(sig_w[2])
  );

  logic       cur_busy, cur_done, cur_pass;
  logic [7:0] cur_sig;
  assign cur_busy = busy_w[sel];
  assign cur_done = done_w[sel];
  assign cur_pass = pass_w[sel];
  assign cur_sig  = sig_w[sel];

  typedef enum {M_IDLE, M_RUN, M_CMP, M_DONE} mst_t;
  mst_t       m_st;
  logic [7:0] m_sig;
  int         m_cnt;
  int         m_pc;
  logic [7:0] sig_q [$];
  logic       pass_q [$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [2:0] r);
    logic [7:0] fb;
    fb = s[7] ? 8'h1D : 8'h00;
    return (s << 1) ^ fb ^ {5'b0, r};
  endfunction

  task automatic step(input logic s, input logic v, input logic [2:0] r);
    @(negedge clk);
    start      = s;
    resp_valid = v;
    resp       = r;
    case (m_st)
      M_IDLE, M_DONE: begin
        if (s) begin
          m_sig = 8'h00;
          m_cnt = 0;
          m_st  = M_RUN;
        end
      end
      M_RUN: begin
        if (v) begin
          m_sig = misr_step(m_sig, r);
          m_cnt++;
          sig_q.push_back(m_sig);
          if (m_cnt == m_pc) m_st = M_CMP;
        end
      end
      M_CMP: begin
        pass_q.push_back(m_sig == golden);
        m_st = M_DONE;
      end
      default: m_st = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    if (sig_q.size() > 0) check_eq("accept_sig", cur_sig, sig_q.pop_front());
    if (pass_q.size() > 0) begin
      check_eq("cmp_done", cur_done, 1);
      check_eq("cmp_pass", cur_pass, pass_q.pop_front());
    end
    check_eq("sig_track", cur_sig, m_sig);
    check_eq("busy", cur_busy, (m_st == M_RUN) || (m_st == M_CMP));
    check_eq("done", cur_done, m_st == M_DONE);
    start      = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic do_reset(input logic s);
    @(negedge clk);
    reset      = 1'b1;
    start      = s;
    resp_valid = 1'b1;
    resp       = 3'd7;
    m_st  = M_IDLE;
    m_sig = 8'h00;
    m_cnt = 0;
    sig_q.delete();
    pass_q.delete();
    @(posedge clk);
    #1;
    check_eq("rst_busy", cur_busy, 0);
    check_eq("rst_done", cur_done, 0);
    check_eq("rst_pass", cur_pass, 0);
    check_eq("rst_sig", cur_sig, 0);
    reset      = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rs [9];
    logic [7:0] g;

    reset      = 1'b1;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp       = 3'd0;
    golden     = 8'h00;
    sel        = 0;
    m_st       = M_IDLE;
    m_sig      = 8'h00;
    m_cnt      = 0;
    m_pc       = 2;
    repeat (2) @(posedge clk);

    // two-pattern session, golden matches
    sel = 0; m_pc = 2;
    do_reset(1'b0);
    step(1'b0, 1'b1, 3'd5);
    golden = 8'h02;
    step(1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd1);
    check_eq("a_sig1", cur_sig, 8'h01);
    step(1'b0, 1'b1, 3'd0);
    check_eq("a_sig2", cur_sig, 8'h02);
    step(1'b0, 1'b0, 3'd0);
    check_eq("a_done", cur_done, 1);
    check_eq("a_pass", cur_pass, 1);

    // nine-pattern session through the feedback tap, golden mismatches, start ignored in RUN/CMP
    sel = 1; m_pc = 9;
    do_reset(1'b0);
    golden = 8'h1C;
    step(1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd1);
    for (int i = 0; i < 7; i++) step(i == 3, 1'b1, 3'd0);
    check_eq("b_sig8", cur_sig, 8'h80);
    step(1'b0, 1'b1, 3'd0);
    check_eq("b_sig9", cur_sig, 8'h1D);
    check_eq("b_cmp_busy", cur_busy, 1);
    step(1'b1, 1'b0, 3'd0);
    check_eq("b_done", cur_done, 1);
    check_eq("b_pass", cur_pass, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd7);
      check_eq("b_hold_sig", cur_sig, 8'h1D);
      check_eq("b_hold_pass", cur_pass, 0);
    end
    step(1'b1, 1'b0, 3'd0);
    check_eq("b_restart_sig", cur_sig, 8'h00);
    check_eq("b_restart_busy", cur_busy, 1);
    check_eq("b_restart_done", cur_done, 0);

    // abort mid-RUN, then a fresh session with random responses
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'($urandom_range(7, 0)));
    do_reset(1'b0);
    step(1'b0, 1'b0, 3'd0);
    g = 8'h00;
    for (int i = 0; i < 9; i++) begin
      rs[i] = 3'($urandom_range(7, 0));
      g = misr_step(g, rs[i]);
    end
    golden = g;
    step(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, rs[i]);
      if (i % 3 == 1) step(1'b0, 1'b0, 3'd6);
    end
    step(1'b0, 1'b0, 3'd0);
    check_eq("c_done", cur_done, 1);
    check_eq("c_pass", cur_pass, 1);
    check_eq("c_sig", cur_sig, g);

    // 63 zero responses with resp_valid toggling
    sel = 2; m_pc = 63;
    do_reset(1'b0);
    golden = 8'h00;
    step(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 63; i++) begin
      step(1'b0, 1'b1, 3'd0);
      if (i < 62) step(1'b0, 1'b0, 3'd0);
    end
    check_eq("d_last_done", cur_done, 0);
    check_eq("d_last_busy", cur_busy, 1);
    step(1'b0, 1'b0, 3'd0);
    check_eq("d_done", cur_done, 1);
    check_eq("d_pass", cur_pass, 1);
    check_eq("d_sig", cur_sig, 8'h00);

    // start and reset together from DONE
    do_reset(1'b1);
    step(1'b0, 1'b0, 3'd0);
    check_eq("e_idle_busy", cur_busy, 0);
    check_eq("e_idle_done", cur_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
